// File: rtl/vecpack_pkg.sv
// Shared element/vector types for the int8 matrix-vector path.
// The packer and the downstream multiply stage both build on these.
package vecpack_pkg;

  localparam int VEC_LEN = 64;
  localparam int DATA_W  = 8;
  localparam int IDX_W   = $clog2(VEC_LEN);

  typedef logic signed [DATA_W-1:0] elem_t;
  typedef elem_t [VEC_LEN-1:0]      vec_t;
  typedef logic [IDX_W-1:0]         idx_t;

endpackage

// File: rtl/vecpack_bank.sv
// One ping-pong buffer of the stream packer: VEC_LEN elements plus a full flag.
// pad_clear zeroes every element above idx in the same cycle as the write.
module vecpack_bank #(
  parameter int VEC_LEN = vecpack_pkg::VEC_LEN,
  parameter int DATA_W  = vecpack_pkg::DATA_W,
  parameter int IDX_W   = $clog2(VEC_LEN)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     we,
  input  logic [IDX_W-1:0]         idx,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic                     pad_clear,
  input  logic                     set_full,
  input  logic                     clear_full,
  output logic                     full,
  output logic signed [DATA_W-1:0] data [VEC_LEN]
);

  import vecpack_pkg::*;

  // set and clear never target the same bank in one cycle, set wins anyway
  always_ff @(posedge clk) begin
    if (!rstn) begin
      full <= 1'b0;
      for (int i = 0; i < VEC_LEN; i++) begin
        data[i] <= '0;
      end
    end else begin
      if (set_full) begin
        full <= 1'b1;
      end else if (clear_full) begin
        full <= 1'b0;
      end
      for (int i = 0; i < VEC_LEN; i++) begin
        if (we && (idx == IDX_W'(i))) begin
          data[i] <= wdata;
        end else if (pad_clear && (IDX_W'(i) > idx)) begin
          data[i] <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/vector_stream_packer.sv
// Byte-serial int8 stream to parallel vector packer, ping-pong double buffered.
// Define VECPACK_ZERO_PAD_EN to zero-pad short vectors instead of dropping them.
module vector_stream_packer #(
  parameter int VEC_LEN = vecpack_pkg::VEC_LEN,
  parameter int DATA_W  = vecpack_pkg::DATA_W,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic                     s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [DATA_W-1:0] m_vector [VEC_LEN],
  output logic                     len_err,
  output logic [CNT_W-1:0]         vec_count
);

  import vecpack_pkg::*;

  localparam int IW = $clog2(VEC_LEN);

  logic                     wbank;
  logic                     rbank;
  logic [IW-1:0]            widx;
  logic                     full0;
  logic                     full1;
  logic signed [DATA_W-1:0] data0 [VEC_LEN];
  logic signed [DATA_W-1:0] data1 [VEC_LEN];

  logic accept;
  logic last_slot;
  logic complete;
  logic restart;
  logic pad_clear;
  logic len_viol;
  logic drain;

  assign s_ready   = wbank ? !full1 : !full0;
  assign m_valid   = rbank ? full1 : full0;
  assign accept    = s_valid && s_ready;
  assign last_slot = (widx == IW'(VEC_LEN - 1));
  assign drain     = m_valid && m_ready;

`ifdef VECPACK_ZERO_PAD_EN
  // an early last closes the vector and zeroes the tail
  assign complete  = accept && (last_slot || s_last);
  assign restart   = 1'b0;
  assign pad_clear = accept && s_last && !last_slot;
  assign len_viol  = accept && last_slot && !s_last;
`else
  // an early last throws the partial vector away and refills the same bank
  assign complete  = accept && last_slot;
  assign restart   = accept && s_last && !last_slot;
  assign pad_clear = 1'b0;
  assign len_viol  = accept && (last_slot ^ s_last);
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wbank     <= 1'b0;
      rbank     <= 1'b0;
      widx      <= '0;
      len_err   <= 1'b0;
      vec_count <= '0;
    end else begin
      len_err <= len_viol;
      if (complete) begin
        widx  <= '0;
        wbank <= !wbank;
      end else if (restart) begin
        widx <= '0;
      end else if (accept) begin
        widx <= widx + IW'(1);
      end
      if (drain) begin
        rbank     <= !rbank;
        vec_count <= vec_count + CNT_W'(1);
      end
    end
  end

  vecpack_bank #(.VEC_LEN(VEC_LEN), .DATA_W(DATA_W), .IDX_W(IW)) bank0 (
    .clk        (clk),
    .rstn       (rstn),
    .we         (accept && !wbank),
    .idx        (widx),
    .wdata      (s_data),
    .pad_clear  (pad_clear && !wbank),
    .set_full   (complete && !wbank),
    .clear_full (drain && !rbank),
    .full       (full0),
    .data       (data0)
  );

  vecpack_bank #(.VEC_LEN(VEC_LEN), .DATA_W(DATA_W), .IDX_W(IW)) bank1 (
    .clk        (clk),
    .rstn       (rstn),
    .we         (accept && wbank),
    .idx        (widx),
    .wdata      (s_data),
    .pad_clear  (pad_clear && wbank),
    .set_full   (complete && wbank),
    .clear_full (drain && rbank),
    .full       (full1),
    .data       (data1)
  );

  always_comb begin
    for (int i = 0; i < VEC_LEN; i++) begin
      m_vector[i] = rbank ? data1[i] : data0[i];
    end
  end

endmodule
